mem_bus_arbiter: RTL and testbench

//  Shares the single-port SOC word memory (instr/data RAM) between the CPU instruction-fetch

---
 rtl/mem_bus_arbiter_pkg.sv | 8 +
 rtl/mem_arb_pick.sv | 21 ++
 rtl/mem_bus_arbiter.sv | 91 +++++++++
 tb/tb_mem_bus_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared state encoding, grant codes and bus widths for the memory arbiter
package mem_bus_arbiter_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;
    localparam logic GNT_INSTR = 1'b0;
    localparam logic GNT_DATA  = 1'b1;
    localparam int WMASK_W = 4;
    localparam int WORD_W  = 32;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: arbitration policy; ARB_RR_EN selects round-robin, otherwise data has fixed priority
module mem_arb_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic i_valid,
    input  logic d_valid,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_sel
);
    assign gnt_valid = i_valid | d_valid;
`ifdef ARB_RR_EN
    // on contention the port that did not win last time goes first
    assign gnt_sel = (i_valid && d_valid) ? ~last_grant : (d_valid ? GNT_DATA : GNT_INSTR);
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    // data port always wins when it asks
    assign gnt_sel = d_valid ? GNT_DATA : GNT_INSTR;
`endif
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one word RAM between fetch and load/store ports (policy set by ARB_RR_EN)
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int MEM_AW = 8,
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_req_valid,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic               i_req_ready,
    output logic               i_rsp_valid,
    output logic [WORD_W-1:0]  i_rdata,
    input  logic               d_req_valid,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [WMASK_W-1:0] d_wmask,
    input  logic [WORD_W-1:0]  d_wdata,
    output logic               d_req_ready,
    output logic               d_rsp_valid,
    output logic [WORD_W-1:0]  d_rdata,
    output logic [MEM_AW-1:0]  mem_addr,
    output logic               mem_rd,
    output logic [WMASK_W-1:0] mem_wmask,
    output logic [WORD_W-1:0]  mem_wdata,
    input  logic [WORD_W-1:0]  mem_rdata
);
    state_t state, next_state;
    logic last_grant, acc_rd, gnt_valid, gnt_sel, hs;
    logic [WORD_W-1:0] i_rdata_q, d_rdata_q;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[ADDR_W-1:MEM_AW+2], i_addr[1:0], d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0]};

    mem_arb_pick u_pick (
        .i_valid    (i_req_valid),
        .d_valid    (d_req_valid),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_sel    (gnt_sel)
    );

    // handshake in IDLE drives the RAM directly; ACCESS always falls back to IDLE
    always_comb begin
        next_state  = state;
        hs          = 1'b0;
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        mem_addr    = '0;
        mem_rd      = 1'b0;
        mem_wmask   = '0;
        mem_wdata   = '0;
        if (state == ST_IDLE && gnt_valid) begin
            hs          = 1'b1;
            next_state  = ST_ACCESS;
            i_req_ready = gnt_sel == GNT_INSTR;
            d_req_ready = gnt_sel == GNT_DATA;
            mem_addr    = gnt_sel == GNT_DATA ? d_addr[MEM_AW+1:2] : i_addr[MEM_AW+1:2];
            mem_rd      = gnt_sel == GNT_INSTR || d_wmask == '0;
            mem_wmask   = gnt_sel == GNT_DATA ? d_wmask : '0;
            mem_wdata   = gnt_sel == GNT_DATA ? d_wdata : '0;
        end else if (state == ST_ACCESS) begin
            next_state = ST_IDLE;
        end
    end

    assign i_rsp_valid = state == ST_ACCESS && last_grant == GNT_INSTR;
    assign d_rsp_valid = state == ST_ACCESS && last_grant == GNT_DATA;
    // read data is forwarded during the response cycle and held afterwards
    assign i_rdata = (i_rsp_valid && acc_rd) ? mem_rdata : i_rdata_q;
    assign d_rdata = (d_rsp_valid && acc_rd) ? mem_rdata : d_rdata_q;

    // state, grant record and held read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= GNT_INSTR;
            acc_rd     <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state <= next_state;
            if (hs) begin
                last_grant <= gnt_sel;
                acc_rd     <= mem_rd;
            end
            if (i_rsp_valid && acc_rd) i_rdata_q <= mem_rdata;
            if (d_rsp_valid && acc_rd) d_rdata_q <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scoreboard bench for mem_bus_arbiter (either ARB_RR_EN setting)
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic i_req_valid, i_req_ready, i_rsp_valid;
    logic [31:0] i_addr, i_rdata;
    logic d_req_valid, d_req_ready, d_rsp_valid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0] d_wmask, mem_wmask;
    logic [7:0] mem_addr;
    logic mem_rd;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] mem [256];

    typedef struct {logic port; logic [31:0] data;} rsp_t;
    rsp_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.MEM_AW(8), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_addr(i_addr), .i_req_ready(i_req_ready),
        .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata),
        .d_req_valid(d_req_valid), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
        .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM model: synchronous read, byte-masked write
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // scoreboard: every response pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (i_rsp_valid || d_rsp_valid) begin
            chk("rsp_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                rsp_t e;
                e = q.pop_front();
                chk("rsp_port", 32'(d_rsp_valid), 32'(e.port));
                chk("rsp_data", e.port ? d_rdata : i_rdata, e.data);
            end
        end
    end

    task automatic do_req(input logic port, input logic [31:0] addr, input logic [3:0] wm,
                          input logic [31:0] wd, input logic [31:0] exp_data, input logic [7:0] exp_ma);
        @(negedge clk);
        if (port) begin
            d_req_valid = 1'b1; d_addr = addr; d_wmask = wm; d_wdata = wd;
        end else begin
            i_req_valid = 1'b1; i_addr = addr;
        end
        q.push_back('{port, exp_data});
        #1;
        chk("ready", port ? d_req_ready : i_req_ready, 32'd1);
        chk("other_ready", port ? i_req_ready : d_req_ready, 32'd0);
        chk("mem_addr", mem_addr, exp_ma);
        chk("mem_rd", mem_rd, wm == 4'd0);
        chk("mem_wmask", mem_wmask, wm);
        @(posedge clk);
        #1;
        chk("ready_in_access", port ? d_req_ready : i_req_ready, 32'd0);
        i_req_valid = 1'b0; d_req_valid = 1'b0; d_wmask = 4'd0;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] order;
        rst_n = 1'b0;
        i_req_valid = 1'b0; i_addr = '0;
        d_req_valid = 1'b0; d_addr = '0; d_wmask = '0; d_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h5000_0000 + i;
        mem[0] = 32'hCAFEF00D; mem[2] = 32'h00A00113; mem[4] = 32'h11223344;
        mem[8] = 32'h88888888; mem[9] = 32'h99999999;
        repeat (2) @(negedge clk);
        chk("rst_i_ready", i_req_ready, 0);
        chk("rst_d_ready", d_req_ready, 0);
        chk("rst_rsp", {i_rsp_valid, d_rsp_valid}, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wmask", mem_wmask, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        rst_n = 1'b1;
        // fetch only
        do_req(1'b0, 32'h08, 4'd0, 32'd0, 32'h00A00113, 8'd2);
        // store then load back with partial mask
        do_req(1'b1, 32'h10, 4'b0011, 32'hDEADBEEF, 32'h0, 8'd4);
        do_req(1'b1, 32'h10, 4'b0000, 32'h0, 32'h1122BEEF, 8'd4);
        // address wraps modulo RAM size
        do_req(1'b1, 32'h400, 4'b0000, 32'h0, 32'hCAFEF00D, 8'd0);
        // reset during ACCESS drops the fetch response
        @(negedge clk);
        i_req_valid = 1'b1; i_addr = 32'h08;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_i_rsp", i_rsp_valid, 0);
        chk("rst_mid_i_rdata", i_rdata, 0);
        chk("rst_mid_d_rdata", d_rdata, 0);
        chk("rst_mid_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, 32'h24, 4'd0, 32'd0, 32'h99999999, 8'd9);
        // contention: both ports valid every IDLE cycle
`ifdef ARB_RR_EN
        order = 4'b0101;
`else
        order = 4'b1111;
`endif
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            i_req_valid = 1'b1; i_addr = 32'h24;
            d_req_valid = 1'b1; d_addr = 32'h20; d_wmask = 4'd0;
            #1;
            if (c % 2 == 0) begin
                chk("arb_d_ready", d_req_ready, 32'(order[c/2]));
                chk("arb_i_ready", i_req_ready, 32'(!order[c/2]));
                q.push_back('{order[c/2], order[c/2] ? 32'h88888888 : 32'h99999999});
            end else begin
                chk("arb_access_ready", {i_req_ready, d_req_ready}, 0);
            end
        end
        @(posedge clk);
        #1;
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        // idle: nothing moves
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_mem_rd", mem_rd, 0);
            chk("idle_mem_wmask", mem_wmask, 0);
            chk("idle_rsp", {i_rsp_valid, d_rsp_valid}, 0);
            chk("idle_i_rdata", i_rdata, 32'h99999999);
            chk("idle_d_rdata", d_rdata, 32'h88888888);
        end
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
